// File: rtl/burst_mode_ctrl.sv
// Burst-mode CellularRAM control FSM: BCR write after reset, then fixed-length synchronous bursts.
// Outputs are registered from the next-state decode, so the strobes line up with the state register.
module burst_mode_ctrl #(
    parameter int LAT_COUNT  = 3,
    parameter int BURST_LEN  = 8,
    parameter int CFG_CYCLES = 4,
    parameter int WAIT_MAX   = 16,
    parameter int REC_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       RdWr,
    input  logic       MemWait,
    output logic [2:0] Mode,
    output logic       MemClkEn,
    output logic       MemCeN,
    output logic       MemAdvN,
    output logic       MemOeN,
    output logic       MemWeN,
    output logic       MemLbN,
    output logic       MemUbN,
    output logic       MemCre,
    output logic       Busy,
    output logic       CfgDone,
    output logic       WordStrobe,
    output logic       Done,
    output logic       Error
);
    localparam int WW   = $clog2(BURST_LEN) + 1;
    localparam int TW   = $clog2(WAIT_MAX + 1);
    localparam int PMAX = (CFG_CYCLES > LAT_COUNT) ?
                          ((CFG_CYCLES > REC_CYCLES) ? CFG_CYCLES : REC_CYCLES) :
                          ((LAT_COUNT > REC_CYCLES) ? LAT_COUNT : REC_CYCLES);
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {S_CFG, S_CFG_END, S_IDLE, S_ADDR, S_LAT, S_XFER, S_REC} state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase_cnt, phase_n;
    logic [WW-1:0] word_cnt, word_n;
    logic [TW-1:0] wait_cnt, wait_n;
    logic          rd_q, rd_n, sample;
    logic [2:0]    mode_d;
    logic          clken_d, cen_d, advn_d, oen_d, wen_d, lbn_d, ubn_d, cre_d;
    logic          busy_d, cfgdone_d, strobe_d, done_d, error_d;

    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt;
        word_n   = word_cnt;
        wait_n   = wait_cnt;
        rd_n     = rd_q;
        sample   = 1'b0;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state)
            S_CFG: begin
                // The cycle spent in reset counts as phase 0, giving CFG_CYCLES visible CFG cycles.
                if (phase_cnt == PW'(CFG_CYCLES)) state_n = S_CFG_END;
                else                              phase_n = phase_cnt + PW'(1);
            end
            S_CFG_END: state_n = S_IDLE;
            S_IDLE: begin
                if (Start) begin
                    state_n = S_ADDR;
                    rd_n    = RdWr;
                end
            end
            S_ADDR: state_n = S_LAT;
            S_LAT: begin
                if (phase_cnt == PW'(LAT_COUNT - 1)) begin
                    state_n = S_XFER;
                    word_n  = '0;
                    wait_n  = '0;
                    sample  = 1'b1;
                end else begin
                    phase_n = phase_cnt + PW'(1);
                end
            end
            S_XFER: begin
                // Word completion is checked first so a final word never reports a timeout.
                if (word_cnt == WW'(BURST_LEN)) begin
                    state_n = S_REC;
                    done_d  = 1'b1;
                end else if (wait_cnt == TW'(WAIT_MAX)) begin
                    state_n = S_REC;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    sample = 1'b1;
                end
            end
            S_REC: begin
                if (phase_cnt == PW'(REC_CYCLES - 1)) state_n = S_IDLE;
                else                                  phase_n = phase_cnt + PW'(1);
            end
            default: state_n = S_CFG;
        endcase

        // WAIT sampled on the edge that opens an XFER cycle decides whether that cycle carries a word.
        if (sample) begin
            if (!MemWait) begin
                strobe_d = 1'b1;
                word_n   = word_n + WW'(1);
                wait_n   = '0;
            end else begin
                wait_n   = wait_n + TW'(1);
            end
        end
        if (state_n != state) phase_n = '0;

        mode_d  = 3'b000;
        clken_d = 1'b0;
        cen_d   = 1'b1;
        advn_d  = 1'b1;
        oen_d   = 1'b1;
        wen_d   = 1'b1;
        lbn_d   = 1'b1;
        ubn_d   = 1'b1;
        cre_d   = 1'b0;
        busy_d  = 1'b1;
        case (state_n)
            S_CFG: begin
                mode_d = 3'b010;
                cen_d  = 1'b0;
                advn_d = 1'b0;
                wen_d  = 1'b0;
                cre_d  = 1'b1;
            end
            S_IDLE: busy_d = 1'b0;
            S_ADDR: begin
                mode_d  = 3'b100;
                clken_d = 1'b1;
                cen_d   = 1'b0;
                advn_d  = 1'b0;
                wen_d   = rd_n;
                lbn_d   = 1'b0;
                ubn_d   = 1'b0;
            end
            S_LAT, S_XFER: begin
                mode_d  = rd_n ? 3'b001 : 3'b011;
                clken_d = 1'b1;
                cen_d   = 1'b0;
                oen_d   = !rd_n;
                lbn_d   = 1'b0;
                ubn_d   = 1'b0;
            end
            default: ;
        endcase
        cfgdone_d = CfgDone | (state_n == S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_CFG;
            phase_cnt  <= '0;
            word_cnt   <= '0;
            wait_cnt   <= '0;
            rd_q       <= 1'b0;
            Mode       <= 3'b000;
            MemClkEn   <= 1'b0;
            MemCeN     <= 1'b1;
            MemAdvN    <= 1'b1;
            MemOeN     <= 1'b1;
            MemWeN     <= 1'b1;
            MemLbN     <= 1'b1;
            MemUbN     <= 1'b1;
            MemCre     <= 1'b0;
            Busy       <= 1'b1;
            CfgDone    <= 1'b0;
            WordStrobe <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_n;
            word_cnt   <= word_n;
            wait_cnt   <= wait_n;
            rd_q       <= rd_n;
            Mode       <= mode_d;
            MemClkEn   <= clken_d;
            MemCeN     <= cen_d;
            MemAdvN    <= advn_d;
            MemOeN     <= oen_d;
            MemWeN     <= wen_d;
            MemLbN     <= lbn_d;
            MemUbN     <= ubn_d;
            MemCre     <= cre_d;
            Busy       <= busy_d;
            CfgDone    <= cfgdone_d;
            WordStrobe <= strobe_d;
            Done       <= done_d;
            Error      <= error_d;
        end
    end
endmodule
